// File: rtl/dso_acq_ctrl_if.sv
// Acquisition-control bundle between the scope front panel/sampler and dso_acq_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; commands are single-cycle pulses or levels, status is free-running.
//
// Signals:
//   deci_rate   decimation divisor, one sample every deci_rate+1 clocks
//   run_stop    pulse, toggles run/stop
//   single      pulse, requests a single-shot acquisition
//   auto_mode   level, 1 = auto trigger, 0 = normal trigger
//   trig_flag   level, trigger detected by the sampler
//   wr_over     pulse, display frame finished
//   deci_valid  decimated sample strobe
//   wave_run    acquisition enable to the sampler
//   force_trig  one-cycle auto-trigger request
//   acq_state   current acquisition state (0 STOP, 1 ARM, 2 WAIT_TRIG, 3 HOLD)
//   single_mode current acquisition is single-shot
interface dso_acq_ctrl_if #(
  parameter int DECI_W = 10
);
  logic [DECI_W-1:0] deci_rate;
  logic              run_stop;
  logic              single;
  logic              auto_mode;
  logic              trig_flag;
  logic              wr_over;
  logic              deci_valid;
  logic              wave_run;
  logic              force_trig;
  logic [1:0]        acq_state;
  logic              single_mode;

  // Command side: front panel / sampler driving the controller.
  modport master (
    output deci_rate, run_stop, single, auto_mode, trig_flag, wr_over,
    input  deci_valid, wave_run, force_trig, acq_state, single_mode
  );

  // Controller side.
  modport slave (
    input  deci_rate, run_stop, single, auto_mode, trig_flag, wr_over,
    output deci_valid, wave_run, force_trig, acq_state, single_mode
  );
endinterface

// File: rtl/dso_acq_ctrl.sv
// Oscilloscope acquisition controller: sample decimator plus STOP/ARM/WAIT_TRIG/HOLD sequencer.
// Latency: all outputs registered, one ad_clk after the inputs that cause them.
// Backpressure: none; pulses are acted on in the cycle they are sampled, never queued.
//
// Ports:
//   ad_clk  single clock
//   rst_n   asynchronous active-low reset, returns to STOP with everything cleared
//   acq     dso_acq_ctrl_if.slave (commands in, deci_valid/wave_run/force_trig/acq_state/single_mode out)
module dso_acq_ctrl #(
  parameter int DECI_W  = 10,
  parameter int PRE_CNT = 512,
  parameter int AUTO_TO = 1000000
) (
  input  logic           ad_clk,
  input  logic           rst_n,
  dso_acq_ctrl_if.slave  acq
);

  localparam int PRE_W = $clog2(PRE_CNT) + 1;
  localparam int TO_W  = $clog2(AUTO_TO) + 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_CNT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(AUTO_TO - 1);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // ---------------------------------------------------------------------------
  // Decimator. Runs in every state so the sampler timing never depends on the
  // sequencer. The >= compare lets a divisor change mid-count take effect at
  // once instead of waiting for the counter to wrap.
  // ---------------------------------------------------------------------------
  logic [DECI_W-1:0] deci_cnt;
  logic              deci_hit;
  logic              deci_valid_q;

  assign deci_hit = (deci_cnt >= acq.deci_rate);

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      deci_cnt     <= '0;
      deci_valid_q <= 1'b0;
    end else begin
      deci_valid_q <= deci_hit;
      deci_cnt     <= deci_hit ? '0 : deci_cnt + DECI_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  logic [1:0]       st_q,      st_nxt;
  logic             single_q,  single_nxt;
  logic [PRE_W-1:0] pre_cnt,   pre_nxt;
  logic [TO_W-1:0]  to_cnt,    to_nxt;
  logic             force_q,   force_nxt;
  logic             wave_run_q;

  always_comb begin
    st_nxt     = st_q;
    single_nxt = single_q;
    pre_nxt    = pre_cnt;
    to_nxt     = to_cnt;
    force_nxt  = 1'b0;

    // A run_stop while acquiring always stops, whatever else is happening.
    if (st_q != ST_STOP && acq.run_stop) begin
      st_nxt     = ST_STOP;
      single_nxt = 1'b0;
    end else begin
      case (st_q)
        ST_STOP: begin
          if (acq.run_stop) begin
            st_nxt     = ST_ARM;
            single_nxt = 1'b0;
          end else if (acq.single) begin
            st_nxt     = ST_ARM;
            single_nxt = 1'b1;
          end
        end

        // Collect the pre-trigger window before a trigger may be accepted.
        ST_ARM: begin
          if (acq.single) single_nxt = 1'b1;
          if (deci_valid_q) begin
            if (pre_cnt == PRE_LAST) st_nxt = ST_WAIT;
            else                     pre_nxt = pre_cnt + PRE_W'(1);
          end
        end

        // A real trigger beats an auto timeout landing in the same cycle; the
        // timeout only fires while we actually stay here.
        ST_WAIT: begin
          if (acq.single) single_nxt = 1'b1;
          if (acq.trig_flag) begin
            st_nxt = ST_HOLD;
          end else if (acq.auto_mode) begin
            if (to_cnt == TO_LAST) begin
              to_nxt    = '0;
              force_nxt = 1'b1;
            end else begin
              to_nxt = to_cnt + TO_W'(1);
            end
          end else begin
            to_nxt = '0;
          end
        end

        // Frame end decides on the single_mode that was in force for this
        // acquisition; a single pulse arriving with wr_over arms the next
        // acquisition as single-shot.
        default: begin
          if (acq.wr_over) begin
            if (single_q) begin
              st_nxt     = ST_STOP;
              single_nxt = 1'b0;
            end else begin
              st_nxt     = ST_ARM;
              single_nxt = acq.single;
            end
          end else if (acq.single) begin
            single_nxt = 1'b1;
          end
        end
      endcase
    end

    // Every state change starts both counters from zero.
    if (st_nxt != st_q) begin
      pre_nxt = '0;
      to_nxt  = '0;
    end
  end

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_STOP;
      single_q   <= 1'b0;
      pre_cnt    <= '0;
      to_cnt     <= '0;
      force_q    <= 1'b0;
      wave_run_q <= 1'b0;
    end else begin
      st_q       <= st_nxt;
      single_q   <= single_nxt;
      pre_cnt    <= pre_nxt;
      to_cnt     <= to_nxt;
      force_q    <= force_nxt;
      // Registered from the next state so it tracks acq_state exactly and is
      // still high in the cycle wr_over is sampled in HOLD.
      wave_run_q <= (st_nxt != ST_STOP);
    end
  end

  assign acq.deci_valid  = deci_valid_q;
  assign acq.wave_run    = wave_run_q;
  assign acq.force_trig  = force_q;
  assign acq.acq_state   = st_q;
  assign acq.single_mode = single_q;

endmodule

// File: tb/tb_dso_acq_ctrl.sv
// Self-checking bench for dso_acq_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural reference model.
module tb_dso_acq_ctrl;

  localparam int DECI_W = 10;
  localparam int PRE_N  = 512;
  localparam int AUTO_N = 100;

  localparam int M_STOP = 0;
  localparam int M_ARM  = 1;
  localparam int M_WAIT = 2;
  localparam int M_HOLD = 3;

  logic ad_clk = 1'b0;
  logic rst_n  = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  dso_acq_ctrl_if #(.DECI_W(DECI_W)) acq_if ();

  dso_acq_ctrl #(
    .DECI_W (DECI_W),
    .PRE_CNT(PRE_N),
    .AUTO_TO(AUTO_N)
  ) dut (
    .ad_clk(ad_clk),
    .rst_n (rst_n),
    .acq   (acq_if)
  );

  always #5 ad_clk = ~ad_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: "samples collected" and "cycles waited" counters plus the
  // scope's mode, stepped once per clock from the inputs the DUT samples.
  // ---------------------------------------------------------------------------
  int m_state  = M_STOP;
  bit m_single = 0;
  bit m_run    = 0;
  bit m_force  = 0;
  bit m_dv     = 0;
  int m_since  = 0;
  int m_pre    = 0;
  int m_wait   = 0;

  task automatic m_reset();
    m_state = M_STOP; m_single = 0; m_run = 0; m_force = 0;
    m_dv = 0; m_since = 0; m_pre = 0; m_wait = 0;
  endtask

  task automatic m_step();
    int nxt;
    bit ns, frc;
    nxt = m_state; ns = m_single; frc = 0;
    if (acq_if.run_stop && m_state != M_STOP) begin
      nxt = M_STOP; ns = 0;
    end else begin
      case (m_state)
        M_STOP: begin
          if (acq_if.run_stop)    begin nxt = M_ARM; ns = 0; end
          else if (acq_if.single) begin nxt = M_ARM; ns = 1; end
        end
        M_ARM: begin
          if (acq_if.single) ns = 1;
          if (m_dv) begin
            m_pre++;
            if (m_pre == PRE_N) nxt = M_WAIT;
          end
        end
        M_WAIT: begin
          if (acq_if.single) ns = 1;
          if (acq_if.trig_flag) nxt = M_HOLD;
          else if (acq_if.auto_mode) begin
            m_wait++;
            if (m_wait == AUTO_N) begin frc = 1; m_wait = 0; end
          end else m_wait = 0;
        end
        default: begin
          if (acq_if.wr_over) begin
            if (m_single) begin nxt = M_STOP; ns = 0; end
            else          begin nxt = M_ARM;  ns = acq_if.single; end
          end else if (acq_if.single) ns = 1;
        end
      endcase
    end
    if (nxt != m_state) begin m_pre = 0; m_wait = 0; end
    // Sample strobe: one every deci_rate+1 clocks since the last one.
    if (m_since >= int'(acq_if.deci_rate)) begin m_dv = 1; m_since = 0; end
    else begin m_dv = 0; m_since++; end
    m_force = frc; m_run = (nxt != M_STOP); m_state = nxt; m_single = ns;
  endtask

  always @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  function automatic logic [31:0] dut_outs();
    return {26'd0, acq_if.deci_valid, acq_if.wave_run, acq_if.force_trig,
            acq_if.acq_state, acq_if.single_mode};
  endfunction

  bit cmp_on = 0;
  always @(negedge ad_clk) begin
    if (cmp_on)
      chk("cycle", dut_outs(),
          {26'd0, m_dv, m_run, m_force, 2'(m_state), m_single});
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge; return at a falling edge).
  // ---------------------------------------------------------------------------
  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int n = 0;
    while (acq_if.acq_state !== s && n < budget) begin
      @(negedge ad_clk);
      n++;
    end
    chk(tag, 32'(acq_if.acq_state), 32'(s));
  endtask

  task automatic pulse_rs();   acq_if.run_stop  = 1; @(negedge ad_clk); acq_if.run_stop  = 0; endtask
  task automatic pulse_sgl();  acq_if.single    = 1; @(negedge ad_clk); acq_if.single    = 0; endtask
  task automatic pulse_trig(); acq_if.trig_flag = 1; @(negedge ad_clk); acq_if.trig_flag = 0; endtask
  task automatic pulse_wr();   acq_if.wr_over   = 1; @(negedge ad_clk); acq_if.wr_over   = 0; endtask

  initial begin
    int cnt, bad, first, second, nf;

    acq_if.deci_rate = 10'd3;
    acq_if.run_stop  = 0;
    acq_if.single    = 0;
    acq_if.auto_mode = 0;
    acq_if.trig_flag = 0;
    acq_if.wr_over   = 0;

    // Reset values
    #1 rst_n = 0;
    #1 chk("rst_outs", dut_outs(), 32'd0);

    // Decimation: every 4th cycle at deci_rate=3, first one 4 cycles after release
    @(negedge ad_clk); @(negedge ad_clk);
    rst_n  = 1;
    cmp_on = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge ad_clk);
      chk("deci_r3", 32'(acq_if.deci_valid), 32'((k % 4) == 0));
    end
    @(negedge ad_clk);
    acq_if.deci_rate = 10'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge ad_clk);
      chk("deci_r0", 32'(acq_if.deci_valid), 32'd1);
    end
    chk("idle_stop", 32'(acq_if.acq_state), 32'd0);

    // Normal run: 512 cycles in ARM, then trigger, frame end re-arms
    pulse_rs();
    cnt = 0; bad = 0;
    while (acq_if.acq_state == 2'd1 && cnt < 600) begin
      if (acq_if.wave_run !== 1'b1) bad++;
      cnt++;
      @(negedge ad_clk);
    end
    chk("arm_len", 32'(cnt), 32'(PRE_N));
    chk("to_wait", 32'(acq_if.acq_state), 32'd2);
    pulse_trig();
    chk("to_hold", 32'(acq_if.acq_state), 32'd3);
    if (acq_if.wave_run !== 1'b1) bad++;
    pulse_wr();
    chk("rearm", 32'(acq_if.acq_state), 32'd1);
    if (acq_if.wave_run !== 1'b1) bad++;
    chk("run_high", 32'(bad), 32'd0);
    pulse_rs();
    chk("stopped", {30'd0, acq_if.wave_run, 1'b0} | 32'(acq_if.acq_state), 32'd0);

    // Single shot
    pulse_sgl();
    chk("sgl_arm",  32'(acq_if.acq_state), 32'd1);
    chk("sgl_mode", 32'(acq_if.single_mode), 32'd1);
    wait_state(2'd2, 700, "sgl_wait");
    pulse_trig();
    chk("sgl_hold", 32'(acq_if.acq_state), 32'd3);
    pulse_wr();
    chk("sgl_done", {29'd0, acq_if.wave_run, acq_if.acq_state} | 32'(acq_if.single_mode), 32'd0);

    // Auto timeout
    acq_if.auto_mode = 1;
    pulse_rs();
    wait_state(2'd2, 700, "auto_wait");
    first = -1; second = -1; nf = 0;
    for (int n = 1; n <= 205; n++) begin
      @(negedge ad_clk);
      if (acq_if.force_trig === 1'b1) begin
        if (nf == 0) first = n;
        else if (nf == 1) second = n;
        nf++;
      end
    end
    chk("force_1st", 32'(first), 32'd100);
    chk("force_2nd", 32'(second), 32'd200);
    chk("force_cnt", 32'(nf), 32'd2);
    chk("auto_stay", 32'(acq_if.acq_state), 32'd2);
    pulse_trig();
    chk("auto_hold", 32'(acq_if.acq_state), 32'd3);
    pulse_wr();
    acq_if.auto_mode = 0;
    wait_state(2'd2, 700, "norm_wait");
    nf = 0;
    for (int n = 0; n < 250; n++) begin
      @(negedge ad_clk);
      if (acq_if.force_trig !== 1'b0) nf++;
    end
    chk("no_force", 32'(nf), 32'd0);
    pulse_trig();
    chk("norm_hold", 32'(acq_if.acq_state), 32'd3);

    // Priority: run_stop beats wr_over in HOLD; run_stop beats single in STOP
    acq_if.run_stop = 1; acq_if.wr_over = 1;
    @(negedge ad_clk);
    acq_if.run_stop = 0; acq_if.wr_over = 0;
    chk("prio_stop", 32'(acq_if.acq_state), 32'd0);
    chk("prio_run",  32'(acq_if.wave_run), 32'd0);
    acq_if.run_stop = 1; acq_if.single = 1;
    @(negedge ad_clk);
    acq_if.run_stop = 0; acq_if.single = 0;
    chk("prio_arm", 32'(acq_if.acq_state), 32'd1);
    chk("prio_sgl", 32'(acq_if.single_mode), 32'd0);

    // Reset during WAIT_TRIG
    wait_state(2'd2, 700, "rst_wait");
    #2 rst_n = 0;
    #1 chk("rst_mid", dut_outs(), 32'd0);
    @(negedge ad_clk);
    rst_n = 1;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge ad_clk);
      if (acq_if.acq_state !== 2'd0) bad++;
    end
    chk("rst_idle", 32'(bad), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 8000; n++) begin
      @(negedge ad_clk);
      acq_if.run_stop  = (m_state == M_STOP) ? ($urandom_range(0, 49) == 0)
                                             : ($urandom_range(0, 1999) == 0);
      acq_if.single    = ($urandom_range(0, 399) == 0);
      acq_if.trig_flag = ($urandom_range(0, 149) == 0);
      acq_if.wr_over   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 699) == 0) acq_if.auto_mode = ~acq_if.auto_mode;
      if ($urandom_range(0, 499) == 0) acq_if.deci_rate = 10'($urandom_range(0, 3));
      if ($urandom_range(0, 3999) == 0) begin
        #2 rst_n = 0;
        @(negedge ad_clk);
        rst_n = 1;
      end
    end
    @(negedge ad_clk);
    cmp_on = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dso_acq_ctrl.md
DSO_ACQ_CTRL -- requirements
Module: dso_acq_ctrl

Interface
REQ-001 SHALL have parameter DECI_W, default 10, width of the decimation-divisor input.
REQ-002 SHALL have parameter PRE_CNT, default 512, the number of decimated samples collected in ARM before triggering is allowed.
REQ-003 SHALL have parameter AUTO_TO, default 1000000, the ad_clk cycles spent in WAIT_TRIG before an auto force-trigger.
REQ-004 SHALL have ports, clock and reset first:
- ad_clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- deci_rate  in  DECI_W  decimation divisor; one sample every deci_rate+1 clocks.
- run_stop  in  1  one-cycle pulse that toggles run/stop.
- single  in  1  one-cycle pulse requesting a single-shot acquisition.
- auto_mode  in  1  1 = auto trigger, 0 = normal trigger.
- trig_flag  in  1  trigger detected by the sampler (level).
- wr_over  in  1  one-cycle pulse: display frame finished.
- deci_valid  out  1  decimated sample strobe.
- wave_run  out  1  acquisition enable to the sampler.
- force_trig  out  1  one-cycle auto-trigger request.
- acq_state  out  2  current state encoding.
- single_mode  out  1  the current acquisition is single-shot.

Function
REQ-005 SHALL count ad_clk cycles in deci_cnt (width DECI_W) and assert deci_valid for exactly one cycle when deci_cnt >= deci_rate; deci_cnt returns to 0 on that cycle, otherwise it increments.
- deci_rate = 0 gives deci_valid on every cycle.
- A deci_rate change mid-count takes effect immediately through the >= compare; no intermediate wrap is allowed.
REQ-006 SHALL run the decimator in every state, including STOP.
REQ-007 SHALL implement an FSM with states STOP=0, ARM=1, WAIT_TRIG=2, HOLD=3, output directly on acq_state.
REQ-008 In STOP:
- A run_stop pulse goes to ARM with single_mode=0.
- Otherwise a single pulse goes to ARM with single_mode=1.
- If both pulses arrive in the same cycle, run_stop wins.
REQ-009 In ARM, pre_cnt SHALL increment on each deci_valid; the cycle that deci_valid arrives with pre_cnt = PRE_CNT-1 SHALL go to WAIT_TRIG and clear pre_cnt.
REQ-010 On entry to ARM, pre_cnt SHALL be 0.
REQ-011 In WAIT_TRIG, trig_flag=1 SHALL go to HOLD next cycle and clear to_cnt.
REQ-012 In WAIT_TRIG with auto_mode=1:
- to_cnt increments every cycle.
- When to_cnt = AUTO_TO-1, force_trig is high for one cycle and to_cnt clears; the FSM stays in WAIT_TRIG.
- force_trig repeats each AUTO_TO cycles until trig_flag arrives.
REQ-013 In WAIT_TRIG with auto_mode=0, to_cnt SHALL hold at 0 and force_trig SHALL stay 0.
REQ-014 In HOLD, wr_over SHALL go to STOP if single_mode=1, otherwise to ARM.
REQ-015 A run_stop pulse in ARM, WAIT_TRIG or HOLD SHALL go to STOP next cycle, clear single_mode, and take priority over every other transition in the same cycle.
REQ-016 A single pulse in ARM, WAIT_TRIG or HOLD SHALL set single_mode=1 without changing state.
REQ-017 wave_run SHALL be registered, 1 in ARM, WAIT_TRIG and HOLD, and 0 in STOP, so it is still 1 in the cycle wr_over is sampled in HOLD.
REQ-018 Counters SHALL saturate-free wrap only as specified:
- pre_cnt width is $clog2(PRE_CNT)+1.
- to_cnt width is $clog2(AUTO_TO)+1.
- Both clear on every state change.
REQ-019 Inputs arriving in states where they are not listed (trig_flag outside WAIT_TRIG, wr_over outside HOLD) SHALL be ignored.

Reset
REQ-020 While rst_n=0, asynchronously:
- Outputs: deci_valid=0, wave_run=0, force_trig=0, acq_state=0 (STOP), single_mode=0.
- Counters deci_cnt, pre_cnt and to_cnt are all 0.
REQ-021 A reset mid-acquisition SHALL abandon the acquisition; after release the block idles in STOP until a run_stop or single pulse.
REQ-022 The first deci_valid after reset release SHALL occur deci_rate+1 cycles after release.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Decimation: deci_rate=3 → deci_valid every 4th cycle; change to 0 mid-count → deci_valid on every following cycle.
- Normal run, deci_rate=0, PRE_CNT=512, auto_mode=0 → acq_state 1 for 512 cycles then 2; trig_flag → 3; wr_over → 1; wave_run stays 1 throughout.
- Single shot: single pulse in STOP → run to HOLD; wr_over → acq_state 0, wave_run 0, single_mode 0.
- Auto timeout, AUTO_TO=100, auto_mode=1, no trigger → force_trig pulses at 100 and 200 cycles after WAIT_TRIG entry; trig_flag → HOLD; with auto_mode=0 force_trig never pulses.
- Priority: run_stop and wr_over in the same cycle in HOLD → STOP; run_stop and single together in STOP → ARM with single_mode=0.
- Reset asserted in WAIT_TRIG → all outputs 0 immediately; after release acq_state stays 0 until a pulse.
